// File: rtl/game_event_uart_tx.sv
// Event-byte UART transmitter: a small FIFO fed by a valid/ready handshake,
// drained by an 8N1/8N2 serialiser driving one idle-high line, LSB first.
module game_event_uart_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ev_valid,
    input  logic [7:0]                    ev_data,
    output logic                          ev_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV      = CLK_HZ / BAUD;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two, at least 2");
        end
        if (DIV < 1) begin : g_bad_div
            $error("CLK_HZ / BAUD must be at least 1");
        end
    endgenerate

    // Handshake: a byte is taken on any rising edge where ev_valid && ev_ready.
    // ev_ready is a function of the registered count only, so a pop on the
    // same edge never makes room for a push on that edge.

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_r;

    assign fifo_empty = (count == '0);
    assign ev_ready   = (count != FULL_LVL);
    assign push       = ev_valid && ev_ready;
    assign fifo_level = count;
    assign tx         = tx_r;
    assign busy       = (state != S_IDLE);

    // The FSM pops whenever it is about to start a frame: from IDLE, or at
    // the last stop-bit cycle so the next frame follows with no gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == S_IDLE) begin
                pop = 1'b1;
            end else if (state == S_STOP && cnt == STOP_LAST) begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ev_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_r    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_r <= 1'b1;
                    cnt  <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        tx_r  <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        tx_r    <= shift[0];
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_r  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx_r    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == STOP_LAST) begin
                        cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx_r  <= 1'b0;
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_r  <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
